decode_ctrl_stage: RTL and testbench

Registered, handshaked successor to the core's combinational decode control.
- Decodes a full 32-bit instruction, not only its opcode, into a registered control bundle with valid/ready flow control.
- Adds illegal-instruction flagging and optional RV32M detection.
- Stalls its input for the duration of multi-cycle mul/div operations.
- Sits between the fetch/IF-ID register and the execute stage.

---
 rtl/core_pkg.sv | 64 ++++++
 rtl/decode_ctrl_lut.sv | 102 ++++++++++
 rtl/decode_ctrl_stage.sv | 130 +++++++++++++
 tb/tb_decode_ctrl_stage.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode definitions: opcodes, ALU-op and writeback encodings, and the
// control bundle that travels from decode into execute.
package core_pkg;

  // Base opcodes recognised by the decoder (instr[6:0]).
  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    MISC_MEM  = 7'b0001111,
    SYSTEM    = 7'b1110011
  } inst_type;

  // ALU operation classes handed to the ALU control.
  localparam logic [1:0] ALU_LDST = 2'b00;
  localparam logic [1:0] ALU_I    = 2'b01;
  localparam logic [1:0] ALU_B    = 2'b10;
  localparam logic [1:0] ALU_R    = 2'b11;

  // Writeback source select.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_CSR = 2'd2
  } wb_sel_e;

  // funct7 values accepted on R-type opcodes.
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Decode stage handshake states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_BUSY  = 2'd2
  } stage_state_e;

  // Full control bundle, MSB first.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    wb_sel_e    wb_sel;
    logic       branch;
    logic       alu_src;
    logic       jump;
    logic [1:0] alu_op;
    logic       lui;
    logic       auipc;
    logic       jal;
    logic       r_type;
    logic       csr_type;
    logic       muldiv;
    logic       fence;
    logic       illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/decode_ctrl_lut.sv
// Purely combinational instruction -> control bundle lookup, including
// illegal-instruction detection and optional RV32M / FENCE support.
module decode_ctrl_lut
  import core_pkg::*;
#(
  parameter bit EN_M_EXT = 1'b1,
  parameter bit EN_FENCE = 1'b1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl
);

  logic [6:0]   opcode;
  logic [6:0]   funct7;
  logic         bad;
  ctrl_bundle_t raw;
  logic         unused_fields;

  assign opcode        = instr[6:0];
  assign funct7        = instr[31:25];
  // Register and immediate fields do not affect control decode.
  assign unused_fields = ^instr[24:7];

  // Opcode table, then legality check that strips side-effecting controls.
  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (opcode)
      OP_R: begin
        raw.reg_write = 1'b1;
        raw.alu_op    = ALU_R;
        raw.r_type    = 1'b1;
        if (funct7 == F7_MULDIV) begin
          raw.muldiv = EN_M_EXT;
          bad        = !EN_M_EXT;
        end else if (funct7 != F7_BASE && funct7 != F7_ALT) begin
          bad = 1'b1;
        end
      end
      OP_I: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.alu_op    = ALU_I;
      end
      OP_LOAD: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        raw.mem_write = 1'b1;
        raw.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        raw.branch = 1'b1;
        raw.alu_op = ALU_B;
      end
      OP_JAL: begin
        raw.reg_write = 1'b1;
        raw.jump      = 1'b1;
        raw.jal       = 1'b1;
      end
      OP_JALR: begin
        raw.reg_write = 1'b1;
        raw.jump      = 1'b1;
        raw.alu_src   = 1'b1;
      end
      OP_LUI: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.lui       = 1'b1;
      end
      OP_AUIPC: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.auipc     = 1'b1;
      end
      SYSTEM: begin
        raw.reg_write = 1'b1;
        raw.csr_type  = 1'b1;
        raw.wb_sel    = WB_CSR;
      end
      MISC_MEM: begin
        raw.fence = 1'b1;
        bad       = !EN_FENCE;
      end
      default: bad = 1'b1;
    endcase
    // Compressed / non-32-bit encodings are never legal here.
    if (opcode[1:0] != 2'b11) bad = 1'b1;

    ctrl = raw;
    if (bad) begin
      ctrl.illegal   = 1'b1;
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage with valid/ready handshake on both sides and an
// input stall while a mul/div occupies execute.
module decode_ctrl_stage
  import core_pkg::*;
#(
  parameter bit EN_M_EXT   = 1'b1,
  parameter int MULDIV_LAT = 4,
  parameter bit EN_FENCE   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        reg_write,
  output logic        mem_write,
  output logic [1:0]  mem_csr_to_reg,
  output logic        branch,
  output logic        alu_src,
  output logic        jump,
  output logic [1:0]  alu_op,
  output logic        lui,
  output logic        auipc,
  output logic        jal,
  output logic        r_type,
  output logic        csr_type,
  output logic        muldiv,
  output logic        fence,
  output logic        illegal
);

  // A latency of 1 means mul/div never stalls the front end.
  localparam bit         HAS_STALL  = (MULDIV_LAT > 1);
  localparam logic [4:0] STALL_INIT = 5'(MULDIV_LAT - 1);

  stage_state_e state_reg, state_next;
  logic [4:0]   stall_cnt_reg, stall_cnt_next;
  ctrl_bundle_t bundle_reg, bundle_next;
  ctrl_bundle_t decoded;
  logic         in_accept;

  decode_ctrl_lut #(
    .EN_M_EXT(EN_M_EXT),
    .EN_FENCE(EN_FENCE)
  ) u_lut (
    .instr(instr),
    .ctrl (decoded)
  );

  assign out_valid = (state_reg == ST_VALID);
  // A departing mul/div heads straight into BUSY, so nothing may enter behind it.
  assign in_ready  = (state_reg != ST_BUSY) && (!out_valid || out_ready) &&
                     !(state_reg == ST_VALID && bundle_reg.muldiv && HAS_STALL);
  assign in_accept = in_valid && in_ready;

  // Next-state, stall counter and bundle load; flush beats the handshake.
  always_comb begin
    state_next     = state_reg;
    stall_cnt_next = stall_cnt_reg;
    bundle_next    = bundle_reg;
    if (flush) begin
      state_next     = ST_IDLE;
      stall_cnt_next = 5'd0;
      bundle_next    = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_accept) begin
            state_next  = ST_VALID;
            bundle_next = decoded;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            if (bundle_reg.muldiv && HAS_STALL) begin
              state_next     = ST_BUSY;
              stall_cnt_next = STALL_INIT;
            end else if (in_accept) begin
              bundle_next = decoded;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_BUSY: begin
          if (stall_cnt_reg <= 5'd1) begin
            state_next     = ST_IDLE;
            stall_cnt_next = 5'd0;
          end else begin
            stall_cnt_next = stall_cnt_reg - 5'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State, counter and bundle registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      stall_cnt_reg <= 5'd0;
      bundle_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
      bundle_reg    <= bundle_next;
    end
  end

  assign reg_write      = bundle_reg.reg_write;
  assign mem_write      = bundle_reg.mem_write;
  assign mem_csr_to_reg = bundle_reg.wb_sel;
  assign branch         = bundle_reg.branch;
  assign alu_src        = bundle_reg.alu_src;
  assign jump           = bundle_reg.jump;
  assign alu_op         = bundle_reg.alu_op;
  assign lui            = bundle_reg.lui;
  assign auipc          = bundle_reg.auipc;
  assign jal            = bundle_reg.jal;
  assign r_type         = bundle_reg.r_type;
  assign csr_type       = bundle_reg.csr_type;
  assign muldiv         = bundle_reg.muldiv;
  assign fence          = bundle_reg.fence;
  assign illegal        = bundle_reg.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: a full-featured instance (M, FENCE, latency 4)
// and a minimal one (no M, no FENCE, latency 1) share the same stimulus and are
// tracked by a transaction-level reference model.
module tb_decode_ctrl_stage;
  import core_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        flush;
  logic        out_ready;

  wire         in_ready_a, out_valid_a, in_ready_n, out_valid_n;
  wire  [16:0] obs_a, obs_n;
  ctrl_bundle_t view_a;
  assign view_a = obs_a;

  int tests_run;
  int tests_failed;

  typedef struct {
    bit           valid;
    ctrl_bundle_t b;
    int           stall;
  } mstate_t;

  mstate_t ma, mn;

  decode_ctrl_stage #(.EN_M_EXT(1'b1), .MULDIV_LAT(4), .EN_FENCE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
    .reg_write(obs_a[16]), .mem_write(obs_a[15]), .mem_csr_to_reg(obs_a[14:13]),
    .branch(obs_a[12]), .alu_src(obs_a[11]), .jump(obs_a[10]), .alu_op(obs_a[9:8]),
    .lui(obs_a[7]), .auipc(obs_a[6]), .jal(obs_a[5]), .r_type(obs_a[4]),
    .csr_type(obs_a[3]), .muldiv(obs_a[2]), .fence(obs_a[1]), .illegal(obs_a[0]));

  decode_ctrl_stage #(.EN_M_EXT(1'b0), .MULDIV_LAT(1), .EN_FENCE(1'b0)) dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
    .instr(instr), .flush(flush), .out_valid(out_valid_n), .out_ready(out_ready),
    .reg_write(obs_n[16]), .mem_write(obs_n[15]), .mem_csr_to_reg(obs_n[14:13]),
    .branch(obs_n[12]), .alu_src(obs_n[11]), .jump(obs_n[10]), .alu_op(obs_n[9:8]),
    .lui(obs_n[7]), .auipc(obs_n[6]), .jal(obs_n[5]), .r_type(obs_n[4]),
    .csr_type(obs_n[3]), .muldiv(obs_n[2]), .fence(obs_n[1]), .illegal(obs_n[0]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Reference decode straight from the instruction-set rules.
  function automatic ctrl_bundle_t ref_decode(logic [31:0] i, bit en_m, bit en_f);
    ctrl_bundle_t c;
    bit bad;
    c = '0;
    bad = 1'b0;
    case (i[6:0])
      7'h33: begin
        c.reg_write = 1; c.alu_op = 2'b11; c.r_type = 1;
        if (i[31:25] == 7'h01) begin
          if (en_m) c.muldiv = 1; else bad = 1;
        end else if (i[31:25] != 7'h00 && i[31:25] != 7'h20) bad = 1;
      end
      7'h13: begin c.reg_write = 1; c.alu_src = 1; c.alu_op = 2'b01; end
      7'h03: begin c.reg_write = 1; c.alu_src = 1; c.wb_sel = WB_MEM; end
      7'h23: begin c.mem_write = 1; c.alu_src = 1; end
      7'h63: begin c.branch = 1; c.alu_op = 2'b10; end
      7'h6F: begin c.reg_write = 1; c.jump = 1; c.jal = 1; end
      7'h67: begin c.reg_write = 1; c.jump = 1; c.alu_src = 1; end
      7'h37: begin c.reg_write = 1; c.alu_src = 1; c.lui = 1; end
      7'h17: begin c.reg_write = 1; c.alu_src = 1; c.auipc = 1; end
      7'h73: begin c.reg_write = 1; c.csr_type = 1; c.wb_sel = WB_CSR; end
      7'h0F: begin c.fence = 1; bad = !en_f; end
      default: bad = 1;
    endcase
    if (bad) begin
      c.illegal = 1; c.reg_write = 0; c.mem_write = 0; c.branch = 0; c.jump = 0;
    end
    return c;
  endfunction

  // Can the model stage take an instruction this cycle?
  function automatic bit m_ready(mstate_t s, bit ordy, int lat);
    return (s.stall == 0) && (!s.valid || ordy) && !(s.valid && s.b.muldiv && lat > 1);
  endfunction

  // One clock of the model: a held bundle, a valid flag and stall cycles left.
  function automatic mstate_t m_step(mstate_t s, bit rst, bit fl, bit iv,
                                     logic [31:0] ins, bit ordy, bit en_m, bit en_f, int lat);
    mstate_t r;
    bit take;
    r = s;
    take = iv && m_ready(s, ordy, lat);
    if (rst || fl) begin
      r.valid = 0; r.b = '0; r.stall = 0;
    end else if (s.stall > 0) begin
      r.stall = s.stall - 1;
    end else if (s.valid && ordy) begin
      if (s.b.muldiv && lat > 1) begin
        r.valid = 0; r.stall = lat - 1;
      end else if (take) begin
        r.b = ref_decode(ins, en_m, en_f);
      end else begin
        r.valid = 0;
      end
    end else if (!s.valid && take) begin
      r.valid = 1; r.b = ref_decode(ins, en_m, en_f);
    end
    return r;
  endfunction

  // Advance one clock; models follow the inputs seen at the edge.
  task automatic cycle();
    @(posedge clk);
    ma = m_step(ma, reset, flush, in_valid, instr, out_ready, 1'b1, 1'b1, 4);
    mn = m_step(mn, reset, flush, in_valid, instr, out_ready, 1'b0, 1'b0, 1);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; in_valid = 1; instr = 32'h00B50533; out_ready = 0;
    cycle();
    in_valid = 0;
    cycle();
    tests_run++;
    if (out_valid_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_held: out_valid=%0b expected 1", out_valid_a);
    end
    reset = 1;
    cycle();
    reset = 0;
    tests_run++;
    if ({out_valid_a, obs_a, in_ready_a} !== {1'b0, 17'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state_a: out_valid=%0b bundle=%h in_ready=%0b expected 0/00000/1",
               out_valid_a, obs_a, in_ready_a);
    end
    tests_run++;
    if ({out_valid_n, obs_n, in_ready_n} !== {1'b0, 17'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state_n: out_valid=%0b bundle=%h in_ready=%0b expected 0/00000/1",
               out_valid_n, obs_n, in_ready_n);
    end
  endtask

  task automatic test_add();
    ctrl_bundle_t e;
    e = '0; e.reg_write = 1; e.alu_op = 2'b11; e.r_type = 1;
    out_ready = 1; in_valid = 1; instr = 32'h00B50533;
    cycle();
    in_valid = 0;
    tests_run++;
    if (out_valid_a !== 1'b1 || obs_a !== e) begin
      tests_failed++;
      $display("FAIL add_decode: out_valid=%0b bundle=%h expected 1/%h", out_valid_a, obs_a, e);
    end
    cycle();
    tests_run++;
    if (out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_drain: out_valid=%0b expected 0", out_valid_a);
    end
  endtask

  task automatic test_mul_stall();
    int n;
    out_ready = 1; in_valid = 1; instr = 32'h02B50533;
    cycle();
    in_valid = 0;
    tests_run++;
    if (out_valid_a !== 1'b1 || view_a.muldiv !== 1'b1 || view_a.r_type !== 1'b1 || in_ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_decode: out_valid=%0b muldiv=%0b r_type=%0b in_ready=%0b expected 1/1/1/0",
               out_valid_a, view_a.muldiv, view_a.r_type, in_ready_a);
    end
    cycle();
    n = 0;
    while (in_ready_a === 1'b0 && n < 20) begin
      cycle();
      n++;
    end
    tests_run++;
    if (n != 3 || in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_stall_len: stall cycles=%0d in_ready=%0b expected 3 cycles then 1", n, in_ready_a);
    end
  endtask

  task automatic test_illegal();
    ctrl_bundle_t ea, en;
    logic [31:0] cases [5];
    int n;
    cases = '{32'h02B50533, 32'h00000000, 32'h0000000F, 32'h10B50533, 32'h00000012};
    for (int i = 0; i < 5; i++) begin
      ea = '0; en = '0;
      case (i)
        0: begin
          ea.reg_write = 1; ea.alu_op = 2'b11; ea.r_type = 1; ea.muldiv = 1;
          en.alu_op = 2'b11; en.r_type = 1; en.illegal = 1;
        end
        2: begin ea.fence = 1; en.fence = 1; en.illegal = 1; end
        3: begin
          ea.alu_op = 2'b11; ea.r_type = 1; ea.illegal = 1;
          en.alu_op = 2'b11; en.r_type = 1; en.illegal = 1;
        end
        default: begin ea.illegal = 1; en.illegal = 1; end
      endcase
      in_valid = 1; instr = cases[i]; out_ready = 0;
      cycle();
      in_valid = 0;
      tests_run++;
      if (out_valid_a !== 1'b1 || obs_a !== ea) begin
        tests_failed++;
        $display("FAIL illegal_a[%0d] instr=%h: out_valid=%0b bundle=%h expected 1/%h",
                 i, cases[i], out_valid_a, obs_a, ea);
      end
      tests_run++;
      if (out_valid_n !== 1'b1 || obs_n !== en) begin
        tests_failed++;
        $display("FAIL illegal_n[%0d] instr=%h: out_valid=%0b bundle=%h expected 1/%h",
                 i, cases[i], out_valid_n, obs_n, en);
      end
      out_ready = 1;
      cycle();
      n = 1;
      while (!(in_ready_a && in_ready_n && !out_valid_a && !out_valid_n) && n < 20) begin
        cycle();
        n++;
      end
      tests_run++;
      if (n >= 20) begin
        tests_failed++;
        $display("FAIL illegal_drain[%0d]: stage still busy after %0d cycles, expected idle", i, n);
      end
    end
  endtask

  task automatic test_backpressure();
    ctrl_bundle_t e;
    int xfer;
    e = '0; e.reg_write = 1; e.alu_src = 1; e.wb_sel = WB_MEM;
    in_valid = 1; instr = 32'h0005A503; out_ready = 0;
    cycle();
    instr = 32'h00B50533;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (out_valid_a !== 1'b1 || obs_a !== e || in_ready_a !== 1'b0 || obs_a[14:13] !== 2'b01) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%0b bundle=%h in_ready=%0b expected 1/%h/0",
                 k, out_valid_a, obs_a, in_ready_a, e);
      end
      cycle();
    end
    in_valid = 0; out_ready = 1;
    xfer = 0;
    for (int k = 0; k < 3; k++) begin
      if (out_valid_a && out_ready) xfer++;
      cycle();
    end
    tests_run++;
    if (xfer != 1 || out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: transfers=%0d out_valid=%0b expected 1/0", xfer, out_valid_a);
    end
  endtask

  task automatic test_flush_back_to_back();
    logic [31:0]  s [6];
    ctrl_bundle_t e [6];
    s = '{32'h00B50533, 32'h00A5A023, 32'h00B50463, 32'h008000EF, 32'h123452B7, 32'h30529073};
    for (int i = 0; i < 6; i++) e[i] = '0;
    e[0].reg_write = 1; e[0].alu_op = 2'b11; e[0].r_type = 1;
    e[1].mem_write = 1; e[1].alu_src = 1;
    e[2].branch = 1; e[2].alu_op = 2'b10;
    e[3].reg_write = 1; e[3].jump = 1; e[3].jal = 1;
    e[4].reg_write = 1; e[4].alu_src = 1; e[4].lui = 1;
    e[5].reg_write = 1; e[5].csr_type = 1; e[5].wb_sel = WB_CSR;

    out_ready = 1; in_valid = 1; instr = 32'h02B50533;
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    tests_run++;
    if (in_ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_busy_pre: in_ready=%0b expected 0", in_ready_a);
    end
    flush = 1; in_valid = 1; instr = 32'h00B50533;
    cycle();
    flush = 0; in_valid = 0;
    tests_run++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_busy: in_ready=%0b out_valid=%0b expected 1/0", in_ready_a, out_valid_a);
    end
    flush = 1; in_valid = 1;
    cycle();
    flush = 0; in_valid = 0;
    tests_run++;
    if (out_valid_a !== 1'b0 || out_valid_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop: out_valid_a=%0b out_valid_n=%0b expected 0/0", out_valid_a, out_valid_n);
    end

    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      instr = s[i];
      #1;
      tests_run++;
      if (in_ready_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_ready[%0d]: in_ready=%0b expected 1", i, in_ready_a);
      end
      cycle();
      tests_run++;
      if (out_valid_a !== 1'b1 || obs_a !== e[i]) begin
        tests_failed++;
        $display("FAIL stream_bundle[%0d] instr=%h: out_valid=%0b bundle=%h expected 1/%h",
                 i, s[i], out_valid_a, obs_a, e[i]);
      end
    end
    in_valid = 0;
    cycle();
    tests_run++;
    if (out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_end: out_valid=%0b expected 0", out_valid_a);
    end
  endtask

  task automatic test_random();
    logic [6:0] pool [11];
    int idx;
    pool = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      instr     = $urandom();
      idx       = $urandom_range(0, 12);
      if (idx < 11) instr[6:0] = pool[idx];
      else if (idx == 11) instr[6:0] = 7'h0F;
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: instr[31:25] = 7'h00;
          1: instr[31:25] = 7'h20;
          default: instr[31:25] = 7'h01;
        endcase
      end
      #1;
      tests_run++;
      if (in_ready_a !== m_ready(ma, out_ready, 4) || in_ready_n !== m_ready(mn, out_ready, 1)) begin
        tests_failed++;
        $display("FAIL rand_in_ready[%0d]: a=%0b n=%0b expected a=%0b n=%0b", c,
                 in_ready_a, in_ready_n, m_ready(ma, out_ready, 4), m_ready(mn, out_ready, 1));
      end
      tests_run++;
      if (out_valid_a !== ma.valid || obs_a !== ma.b) begin
        tests_failed++;
        $display("FAIL rand_out_a[%0d]: out_valid=%0b bundle=%h expected %0b/%h", c,
                 out_valid_a, obs_a, ma.valid, ma.b);
      end
      tests_run++;
      if (out_valid_n !== mn.valid || obs_n !== mn.b) begin
        tests_failed++;
        $display("FAIL rand_out_n[%0d]: out_valid=%0b bundle=%h expected %0b/%h", c,
                 out_valid_n, obs_n, mn.valid, mn.b);
      end
      cycle();
    end
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    ma = '{valid: 1'b0, b: '0, stall: 0};
    mn = '{valid: 1'b0, b: '0, stall: 0};
    reset = 1; in_valid = 0; instr = '0; flush = 0; out_ready = 0;
    cycle();
    cycle();
    test_reset();
    test_add();
    test_mul_stall();
    test_illegal();
    test_backpressure();
    test_flush_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
